// File: rtl/wb_spi_pkg.sv
// Shared definitions for the SPI-master Wishbone command path: arbiter states,
// command field layout and the fixed auto-read command words.
package wb_spi_pkg;

    localparam int CMD_W = 34;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STB      = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_GAP      = 2'd3
    } arb_state_t;

    // Opcode lives in the top two bits; bit 33 set marks a read
    localparam int OPC_MSB = 33;
    localparam int OPC_LSB = 32;
    localparam int RD_BIT  = 33;

    localparam logic [CMD_W-1:0] AUTO_RD_CMD  = 34'h200000001;
    localparam logic [CMD_W-1:0] AUTO_RD_NONE = 34'h0;

    function automatic logic is_read(input logic [CMD_W-1:0] cmd);
        return cmd[RD_BIT];
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr,
// wrapping past NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    logic [IDX_W-1:0] pos;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_any    = 1'b0;
        pos        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = (int'(ptr) + i >= NUM_REQ) ? IDX_W'(int'(ptr) + i - NUM_REQ)
                                             : IDX_W'(int'(ptr) + i);
            if (!gnt_any && req[pos]) begin
                gnt_any         = 1'b1;
                gnt_onehot[pos] = 1'b1;
                gnt_idx         = pos;
            end
        end
    end

endmodule

// File: rtl/wb_cmd_arbiter.sv
// Shares the SPI master's single Wishbone command port among NUM_REQ sources:
// round-robin grant, fixed-length strobe, ack wait with timeout, done/err report.
module wb_cmd_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int CMD_W   = wb_spi_pkg::CMD_W,
    parameter int STB_LEN = 2,
    parameter int GAP_LEN = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*CMD_W-1:0] req_cmd,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       req_done,
    output logic                     req_err,
    output logic                     o_stb,
    output logic [CMD_W-1:0]         cmd_word,
    input  logic                     i_ack,
    output logic                     busy,
    output logic [7:0]               err_count
);

    typedef wb_spi_pkg::arb_state_t state_t;

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(wb_spi_pkg::max3(STB_LEN, GAP_LEN, TIMEOUT) + 1);

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   gnt;
    logic [CNT_W-1:0]   cnt;
    logic               ack_seen;

    logic [NUM_REQ-1:0] arb_onehot;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic [IDX_W-1:0]   ptr_next;
    logic [CMD_W-1:0]   arb_cmd;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req        (req_valid),
        .ptr        (ptr),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx),
        .gnt_any    (arb_any)
    );

    assign ptr_next = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
    assign arb_cmd  = req_cmd[int'(arb_idx)*CMD_W +: CMD_W];

    // One counter serves all timed states: strobe length, ack timeout and gap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= wb_spi_pkg::ST_IDLE;
            ptr       <= '0;
            gnt       <= '0;
            cnt       <= '0;
            ack_seen  <= 1'b0;
            cmd_word  <= '0;
            o_stb     <= 1'b0;
            req_ready <= '0;
            req_done  <= '0;
            req_err   <= 1'b0;
            busy      <= 1'b0;
            err_count <= '0;
        end else begin
            req_ready <= '0;
            req_done  <= '0;
            req_err   <= 1'b0;
            case (state)
                wb_spi_pkg::ST_IDLE: begin
                    if (arb_any) begin
                        gnt       <= arb_idx;
                        ptr       <= ptr_next;
                        cmd_word  <= arb_cmd;
                        req_ready <= arb_onehot;
                        o_stb     <= 1'b1;
                        busy      <= 1'b1;
                        cnt       <= CNT_W'(1);
                        ack_seen  <= 1'b0;
                        state     <= wb_spi_pkg::ST_STB;
                    end
                end
                wb_spi_pkg::ST_STB: begin
                    // An early ack is kept so WAIT_ACK can close after one cycle
                    ack_seen <= ack_seen | i_ack;
                    if (cnt == CNT_W'(STB_LEN)) begin
                        o_stb <= 1'b0;
                        cnt   <= '0;
                        state <= wb_spi_pkg::ST_WAIT_ACK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                wb_spi_pkg::ST_WAIT_ACK: begin
                    if (i_ack || ack_seen) begin
                        req_done <= NUM_REQ'(1) << gnt;
                        cnt      <= CNT_W'(1);
                        state    <= wb_spi_pkg::ST_GAP;
                    end else if (cnt == CNT_W'(TIMEOUT)) begin
                        req_done <= NUM_REQ'(1) << gnt;
                        req_err  <= 1'b1;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                        cnt   <= CNT_W'(1);
                        state <= wb_spi_pkg::ST_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                wb_spi_pkg::ST_GAP: begin
                    if (cnt == CNT_W'(GAP_LEN)) begin
                        busy  <= 1'b0;
                        state <= wb_spi_pkg::ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    o_stb <= 1'b0;
                    busy  <= 1'b0;
                    state <= wb_spi_pkg::ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_arbiter.sv
// Directed self-checking bench for wb_cmd_arbiter: grant timing, fairness,
// early ack, timeout and saturation, mid-command reset, spurious acks.
module tb_wb_cmd_arbiter;

    localparam int NR = 3;
    localparam int CW = 34;
    localparam int SL = 2;
    localparam int GL = 1;
    localparam int TO = 20;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR*CW-1:0] req_cmd;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   req_done;
    logic            req_err;
    logic            o_stb;
    logic [CW-1:0]   cmd_word;
    logic            i_ack;
    logic            busy;
    logic [7:0]      err_count;

    logic [CW-1:0]   cmds [NR];
    int              n_checks = 0;
    int              n_pass   = 0;
    int              n_fail   = 0;

    always #5 clk = ~clk;

    wb_cmd_arbiter #(
        .NUM_REQ (NR),
        .CMD_W   (CW),
        .STB_LEN (SL),
        .GAP_LEN (GL),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_cmd   (req_cmd),
        .req_ready (req_ready),
        .req_done  (req_done),
        .req_err   (req_err),
        .o_stb     (o_stb),
        .cmd_word  (cmd_word),
        .i_ack     (i_ack),
        .busy      (busy),
        .err_count (err_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [NR-1:0] valid, input logic ack);
        req_valid = valid;
        i_ack     = ack;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (req_ready != '0) break;
        end
        check_output({tag, "_ready_seen"}, 64'(req_ready != '0), 64'(1));
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (req_done != '0) break;
        end
        check_output({tag, "_done_seen"}, 64'(req_done != '0), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cmds[0] = 34'h1_0000_0011;
        cmds[1] = 34'h0_8000_00A5;
        cmds[2] = 34'h2_0000_0001;
        for (int i = 0; i < NR; i++) req_cmd[i*CW +: CW] = cmds[i];

        rst = 1'b0;
        apply_stimulus(3'b000, 1'b0);
        tick();
        tick();
        check_output("rst_o_stb",     64'(o_stb),     64'(0));
        check_output("rst_busy",      64'(busy),      64'(0));
        check_output("rst_cmd_word",  64'(cmd_word),  64'(0));
        check_output("rst_req_ready", 64'(req_ready), 64'(0));
        check_output("rst_req_done",  64'(req_done),  64'(0));
        check_output("rst_req_err",   64'(req_err),   64'(0));
        check_output("rst_err_count", 64'(err_count), 64'(0));
        rst = 1'b1;
        tick();

        // Single request from requester 1, ack three cycles after strobe ends
        apply_stimulus(3'b010, 1'b0);
        tick();
        check_output("s1_ready",    64'(req_ready), 64'(3'b010));
        check_output("s1_stb1",     64'(o_stb),     64'(1));
        check_output("s1_busy",     64'(busy),      64'(1));
        check_output("s1_cmd_word", 64'(cmd_word),  64'(cmds[1]));
        apply_stimulus(3'b000, 1'b0);
        tick();
        check_output("s1_stb2",     64'(o_stb),     64'(1));
        check_output("s1_ready_1c", 64'(req_ready), 64'(0));
        tick();
        check_output("s1_stb_low",  64'(o_stb),     64'(0));
        tick();
        tick();
        apply_stimulus(3'b000, 1'b1);
        tick();
        apply_stimulus(3'b000, 1'b0);
        check_output("s1_done",     64'(req_done),  64'(3'b010));
        check_output("s1_err",      64'(req_err),   64'(0));
        tick();
        check_output("s1_done_1c",  64'(req_done),  64'(0));
        check_output("s1_idle",     64'(busy),      64'(0));
        check_output("s1_cmd_hold", 64'(cmd_word),  64'(cmds[1]));

        // Reset while waiting for ack; pointer must return to 0
        apply_stimulus(3'b010, 1'b0);
        tick();
        check_output("r_ready", 64'(req_ready), 64'(3'b010));
        apply_stimulus(3'b000, 1'b0);
        tick();
        tick();
        check_output("r_in_wait_busy", 64'(busy), 64'(1));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_output("r_o_stb",    64'(o_stb),    64'(0));
        check_output("r_busy",     64'(busy),     64'(0));
        check_output("r_cmd_word", 64'(cmd_word), 64'(0));
        check_output("r_done",     64'(req_done), 64'(0));
        tick();
        tick();
        check_output("r_no_late_done", 64'(req_done), 64'(0));

        // Fairness with every requester continuously valid
        apply_stimulus(3'b111, 1'b0);
        for (int k = 0; k < 9; k++) begin
            wait_ready("rr", 10);
            check_output("rr_grant", 64'(req_ready), 64'(3'b001 << (k % 3)));
            check_output("rr_cmd",   64'(cmd_word),  64'(cmds[k % 3]));
            tick();
            tick();
            apply_stimulus(3'b111, 1'b1);
            tick();
            apply_stimulus(3'b111, 1'b0);
            check_output("rr_done", 64'(req_done), 64'(3'b001 << (k % 3)));
        end
        apply_stimulus(3'b000, 1'b0);
        tick();

        // Ack during the second strobe cycle
        apply_stimulus(3'b001, 1'b0);
        tick();
        check_output("ea_ready", 64'(req_ready), 64'(3'b001));
        apply_stimulus(3'b000, 1'b0);
        tick();
        apply_stimulus(3'b000, 1'b1);
        tick();
        apply_stimulus(3'b000, 1'b0);
        check_output("ea_wait_stb",  64'(o_stb),    64'(0));
        check_output("ea_wait_done", 64'(req_done), 64'(0));
        tick();
        check_output("ea_done", 64'(req_done), 64'(3'b001));
        check_output("ea_err",  64'(req_err),  64'(0));
        tick();

        // Timeout: done and err together TO+1 cycles after WAIT_ACK entry
        apply_stimulus(3'b100, 1'b0);
        tick();
        check_output("to_ready", 64'(req_ready), 64'(3'b100));
        apply_stimulus(3'b000, 1'b0);
        tick();
        tick();
        repeat (TO) tick();
        check_output("to_not_early", 64'(req_done), 64'(0));
        tick();
        check_output("to_done",      64'(req_done),  64'(3'b100));
        check_output("to_err",       64'(req_err),   64'(1));
        check_output("to_err_count", 64'(err_count), 64'(1));
        tick();
        check_output("to_err_1c", 64'(req_err), 64'(0));
        check_output("to_idle",   64'(busy),    64'(0));

        // Ack on the timeout-terminal cycle wins
        apply_stimulus(3'b001, 1'b0);
        tick();
        check_output("tt_ready", 64'(req_ready), 64'(3'b001));
        apply_stimulus(3'b000, 1'b0);
        tick();
        tick();
        repeat (TO) tick();
        apply_stimulus(3'b000, 1'b1);
        tick();
        apply_stimulus(3'b000, 1'b0);
        check_output("tt_done",      64'(req_done),  64'(3'b001));
        check_output("tt_err",       64'(req_err),   64'(0));
        check_output("tt_err_count", 64'(err_count), 64'(1));

        // Spurious acks in GAP and then IDLE
        apply_stimulus(3'b000, 1'b1);
        tick();
        check_output("sp_gap_busy", 64'(busy),     64'(0));
        check_output("sp_gap_done", 64'(req_done), 64'(0));
        tick();
        tick();
        check_output("sp_idle_busy", 64'(busy),     64'(0));
        check_output("sp_idle_stb",  64'(o_stb),    64'(0));
        check_output("sp_idle_done", 64'(req_done), 64'(0));
        apply_stimulus(3'b000, 1'b0);
        tick();

        // 299 more timeouts: error counter saturates at 255
        for (int s = 0; s < 299; s++) begin
            apply_stimulus(3'b001, 1'b0);
            wait_ready("sat", 10);
            apply_stimulus(3'b000, 1'b0);
            wait_done("sat", TO + 10);
            check_output("sat_err", 64'(req_err), 64'(1));
            if (s == 99) check_output("sat_count_101", 64'(err_count), 64'(101));
        end
        tick();
        check_output("sat_count_255", 64'(err_count), 64'(255));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_cmd_arbiter.md
# wb_cmd_arbiter

Round-robin arbiter and sequencer that shares the single Wishbone command port of the SPI master between several command sources. Typical sources are the host endpoint trigger path, the interrupt-driven auto-read path and the DAC/config sequencer. The block latches one requester's 34-bit command word and drives the strobe for a fixed number of cycles. It then waits for the bus acknowledge, with a timeout, and reports completion to the granted requester.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- CMD_W, 34, command word width
- STB_LEN, 2, cycles o_stb is held high per command (>=1)
- GAP_LEN, 1, idle cycles after completion before next grant (>=1)
- TIMEOUT, 255, WAIT_ACK cycles before abandoning a command (>=1)

Ports:
- clk  in  1  system clock; one clock, all logic on rising edge
- rst  in  1  reset, synchronous and active-low
- req_valid  in  NUM_REQ  per-requester command pending; level, held until req_ready
- req_cmd  in  NUM_REQ*CMD_W  flattened command words; requester i at [i*CMD_W +: CMD_W]
- req_ready  out  NUM_REQ  one-hot, 1-cycle pulse: command of requester i latched
- req_done  out  NUM_REQ  one-hot, 1-cycle pulse: command of requester i finished
- req_err  out  1  1-cycle pulse coincident with req_done when finish was a timeout
- o_stb  out  1  Wishbone strobe to SPI master
- cmd_word  out  CMD_W  command to SPI master; stable from grant until next grant
- i_ack  in  1  Wishbone acknowledge from SPI master
- busy  out  1  high in any state other than IDLE
- err_count  out  8  saturating count of timeouts since reset

## Operation
- States: IDLE, STB, WAIT_ACK, GAP.
- IDLE: if any req_valid, the winner is the first set bit at or after pointer `ptr`, scanning upward with wrap. Latch cmd_word from the winner and record it as `gnt`. Set `ptr` to (gnt+1) mod NUM_REQ. Go to STB.
- STB: o_stb=1 for exactly STB_LEN cycles. req_ready[gnt]=1 in the first STB cycle only. Then go to WAIT_ACK.
- WAIT_ACK: o_stb=0 and the timeout counter increments each cycle.
  - On i_ack, go to GAP with a normal completion.
  - If the counter reaches TIMEOUT without an ack, go to GAP with a timeout completion and increment err_count (saturates at 255).
- GAP: req_done[gnt]=1 in the first GAP cycle; req_err=1 in that same cycle if the completion was a timeout. Hold GAP_LEN cycles, then go to IDLE.
- i_ack seen during STB is remembered. In that case WAIT_ACK lasts exactly 1 cycle and then goes to GAP with normal completion.
- i_ack in IDLE or GAP is ignored.
- If i_ack arrives in the same cycle the timeout count reaches TIMEOUT, the ack wins: no req_err, no err_count increment.
- A requester dropping req_valid after req_ready has no effect. Its req_valid must not be re-sampled before its req_done.
- Reset values: state IDLE, ptr 0, gnt 0, cmd_word 0, o_stb 0, req_ready 0, req_done 0, req_err 0, busy 0, err_count 0.
- Reset during STB/WAIT_ACK/GAP returns to IDLE on that edge. o_stb drops and no req_done is issued.

## Timing
- All outputs are registered.
- req_valid sampled high in IDLE at edge T: o_stb, req_ready and busy are high from cycle T+1. cmd_word is valid from T+1.
- o_stb is high for cycles T+1..T+STB_LEN.
- Ack in WAIT_ACK cycle k: req_done in cycle k+1.
- Minimum command-to-command spacing is STB_LEN+1+GAP_LEN+1 cycles.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0 with no requester skipped.

## Structure
- Shared package (wb_spi_pkg): CMD_W, state encoding localparams, command field positions (bits 33:32 opcode; bit 33 = read), and the auto-read constants 34'h200000001 and 34'h0.
- Sub-module rr_arbiter: combinational; inputs req vector and ptr, outputs one-hot grant and index. The pointer register stays in wb_cmd_arbiter.

## Test plan
- Single request, req 1 valid with cmd 34'h0_8000_00A5, ack 3 cycles after strobe ends:
  - req_ready[1] at T+1; o_stb high T+1..T+2; cmd_word=34'h0_8000_00A5.
  - req_done[1] one cycle after ack; req_err=0.
- All three requesters held valid for 9 commands, ack each time -> grant order 0,1,2,0,1,2,0,1,2.
- No ack -> req_done and req_err pulse together exactly TIMEOUT+1 cycles after WAIT_ACK entry; err_count=1. Repeat 300 times -> err_count saturates at 255.
- Ack in the second STB cycle -> WAIT_ACK lasts 1 cycle; req_done with req_err=0. Ack on the timeout-terminal cycle -> req_err=0 and err_count unchanged.
- rst low during WAIT_ACK -> next cycle: o_stb=0, busy=0, cmd_word=0, no req_done; next request is granted starting from ptr 0.
- Spurious i_ack pulses in IDLE and GAP -> no state change and no extra req_done.
